// File: rtl/sevseg_pkg.sv
// Shared symbol codes, segment patterns and decode for the 7-segment scanner.
// The blink phase type is used only when SEVSEG_BLINK_EN is defined.
package sevseg_pkg;

  localparam logic [3:0] SYM_P     = 4'd10;
  localparam logic [3:0] SYM_UP    = 4'd11;
  localparam logic [3:0] SYM_DOWN  = 4'd12;
  localparam logic [3:0] SYM_DASH  = 4'd13;
  localparam logic [3:0] SYM_BLANK = 4'd15;

  localparam logic [6:0] SEG_OFF = 7'b111_1111;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  // Segments are {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg_decode(
    input logic [3:0] s
  );
    logic [6:0] seg;
    seg = SEG_OFF;
    case (s)
      4'd0:     seg = 7'b100_0000;
      4'd1:     seg = 7'b111_1001;
      4'd2:     seg = 7'b010_0100;
      4'd3:     seg = 7'b011_0000;
      4'd4:     seg = 7'b001_1001;
      4'd5:     seg = 7'b001_0010;
      4'd6:     seg = 7'b000_0010;
      4'd7:     seg = 7'b111_1000;
      4'd8:     seg = 7'b000_0000;
      4'd9:     seg = 7'b001_0000;
      SYM_P:    seg = 7'b000_1100;
      SYM_UP:   seg = 7'b101_1100;
      SYM_DOWN: seg = 7'b110_0011;
      SYM_DASH: seg = 7'b011_1111;
      default:  seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevseg_if.sv
// Producer-side bundle for the scanner: symbol word, load strobe,
// display overrides and the status flags returned to the producer.
interface sevseg_if;

  logic [15:0] sym;
  logic        load;
  logic [3:0]  blink_mask;
  logic        blank;
  logic        busy;
  logic        frame_done;

  modport master (
    output sym,
    output load,
    output blink_mask,
    output blank,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  sym,
    input  load,
    input  blink_mask,
    input  blank,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/sevseg_decoder.sv
// Combinational symbol to active-low segment decoder, shared by
// other display blocks.
module sevseg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg
);

  assign seg = seg_decode(sym);

endmodule

// File: rtl/sevseg_scanner.sv
// 4-digit multiplexed 7-segment driver with frame-aligned commit.
// Define SEVSEG_BLINK_EN to enable per-digit blinking.
module sevseg_scanner
  import sevseg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  sevseg_if.slave    bus,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   staging;
  logic [15:0]   shadow;
  logic          pend;
  logic          frame_done;
  logic          tick;
  logic          boundary;
  logic [3:0]    cur_sym;
  logic [6:0]    cur_seg;
  logic          blink_off;

  assign tick     = (cnt == CW'(SCAN_DIV - 1));
  assign boundary = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load in the boundary cycle lands in staging while shadow
  // takes the older staged value; pend stays set for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= 16'hFFFF;
      shadow  <= 16'hFFFF;
      pend    <= 1'b0;
    end else begin
      if (bus.load)
        staging <= bus.sym;
      if (boundary && pend)
        shadow <= staging;
      if (bus.load)
        pend <= 1'b1;
      else if (boundary)
        pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_done <= 1'b0;
    else
      frame_done <= boundary;
  end

  assign bus.busy       = pend;
  assign bus.frame_done = frame_done;

  assign cur_sym = shadow[{idx, 2'b00} +: 4];

  sevseg_decoder u_dec (
    .sym (cur_sym),
    .seg (cur_seg)
  );

`ifdef SEVSEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt;
  phase_e        phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= PH_ON;
    end else if (boundary) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blink_off = (phase == PH_OFF) && bus.blink_mask[idx];
`else
  logic unused_blink;
  assign unused_blink = (^bus.blink_mask) ^ (BLINK_FRAMES > 0);
  assign blink_off    = 1'b0;
`endif

  // Overrides gate segments only; digit scanning never stops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DIGIT   <= 4'b1111;
      DISPLAY <= SEG_OFF;
    end else begin
      DIGIT <= ~(4'b0001 << idx);
      if (bus.blank || blink_off)
        DISPLAY <= SEG_OFF;
      else
        DISPLAY <= cur_seg;
    end
  end

endmodule

// File: tb/tb_sevseg_scanner.sv
// Directed bench for sevseg_scanner at SCAN_DIV=4, BLINK_FRAMES=2.
// Expects digit 0 to blink when built with SEVSEG_BLINK_EN.
module tb_sevseg_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] digit;
  logic [6:0] display;

  int vecs;
  int errs;
  int e;

  logic [6:0] exp_seg [4];

  sevseg_if bus ();

  sevseg_scanner #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .DIGIT   (digit),
    .DISPLAY (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] expv
  );
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s e=%0d got %0h expected %0h", tag, e, obs, expv);
    end
  endtask

  task automatic set_exp(
    input logic [6:0] d0,
    input logic [6:0] d1,
    input logic [6:0] d2,
    input logic [6:0] d3
  );
    exp_seg[0] = d0;
    exp_seg[1] = d1;
    exp_seg[2] = d2;
    exp_seg[3] = d3;
  endtask

  task automatic step();
    int         slot;
    int         fi;
    logic [3:0] ed;
    logic [6:0] es;
    logic       off;
    @(posedge clk);
    #1;
    e++;
    slot = ((e - 1) % 16) / 4;
    fi   = (e - 1) / 16;
    ed   = ~(4'b0001 << slot);
    off  = 1'b0;
`ifdef SEVSEG_BLINK_EN
    off = ((fi / 2) % 2 == 1) && (slot == 0);
`endif
    if (bus.blank || off)
      es = 7'h7F;
    else
      es = exp_seg[slot];
    chk("digit", 16'(digit), 16'(ed));
    chk("display", 16'(display), 16'(es));
    chk("frame_done", 16'(bus.frame_done), 16'(e % 16 == 0));
  endtask

  task automatic step_to(input int n);
    while (e < n) step();
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.sym  = w;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    vecs           = 0;
    errs           = 0;
    e              = 0;
    rst            = 1'b0;
    bus.sym        = 16'h0;
    bus.load       = 1'b0;
    bus.blank      = 1'b0;
    bus.blink_mask = 4'b0001;
    set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F);

    #1 rst = 1'b1;
    #1;
    chk("rst_digit", 16'(digit), 16'hF);
    chk("rst_display", 16'(display), 16'h7F);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_fd", 16'(bus.frame_done), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e = 0;

    step_to(1);
    load_word(16'hB123);
    chk("busy_after_load", 16'(bus.busy), 16'h1);
    step_to(15);
    chk("busy_pre_commit", 16'(bus.busy), 16'h1);
    step();
    chk("busy_commit", 16'(bus.busy), 16'h0);

    set_exp(7'h30, 7'h24, 7'h79, 7'h5C);
    step_to(18);
    load_word(16'h1111);
    chk("busy_load1", 16'(bus.busy), 16'h1);
    step_to(31);
    load_word(16'h2222);
    chk("busy_collide", 16'(bus.busy), 16'h1);

    set_exp(7'h79, 7'h79, 7'h79, 7'h79);
    step_to(47);
    chk("busy_pre_32", 16'(bus.busy), 16'h1);
    step();
    chk("busy_commit2", 16'(bus.busy), 16'h0);

    set_exp(7'h24, 7'h24, 7'h24, 7'h24);
    step_to(54);
    bus.blank = 1'b1;
    step_to(58);
    bus.blank = 1'b0;
    step_to(59);
    load_word(16'hDA0C);
    step_to(64);

    set_exp(7'h63, 7'h40, 7'h0C, 7'h3F);
    step_to(65);
    load_word(16'h795E);
    step_to(80);

    set_exp(7'h7F, 7'h12, 7'h10, 7'h78);
    step_to(97);
    load_word(16'h8888);
    chk("busy_before_rst", 16'(bus.busy), 16'h1);
    step_to(104);

    rst = 1'b1;
    #1;
    chk("mid_rst_digit", 16'(digit), 16'hF);
    chk("mid_rst_display", 16'(display), 16'h7F);
    chk("mid_rst_busy", 16'(bus.busy), 16'h0);
    chk("mid_rst_fd", 16'(bus.frame_done), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e = 0;
    set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    step_to(16);
    chk("busy_discard", 16'(bus.busy), 16'h0);
    step_to(32);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sevseg_scanner.md
# sevseg_scanner

Time-multiplexed driver for the 4-digit, active-low 7-segment display on the lab board. It sits downstream of the counter/state-machine blocks. It accepts four 4-bit symbol codes as a packed word and stages them for a tear-free commit at frame boundaries. It scans the digits at a fixed slot rate, decodes each symbol to segments, and optionally blinks selected digits.

## Interface
- SCAN_DIV, 100000: clocks per digit slot (1 kHz slot rate at 100 MHz); must be ≥ 2
- BLINK_FRAMES, 125: frames per blink half-period (used only with SEVSEG_BLINK_EN)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- sym  in  16  symbol codes; sym[3:0] = rightmost digit (idx 0), sym[15:12] = leftmost (idx 3)
- load  in  1  capture sym into the staging register this cycle
- blink_mask  in  4  per-digit blink enable; bit i is digit idx i
- blank  in  1  force all segments off; scanning continues
- DIGIT  out  4  digit enables, active-low, one-hot-low
- DISPLAY  out  7  segments {g,f,e,d,c,b,a}, active-low
- busy  out  1  a staged value is pending commit
- frame_done  out  1  one-cycle pulse per completed frame

## Operation
- Reset values:
  - cnt=0, idx=0
  - staging=shadow=16'hFFFF (all blank)
  - pend=0, busy=0, frame_done=0
  - DIGIT=4'b1111, DISPLAY=7'b111_1111
  - blink phase=ON, frame counter=0
- Slot counter:
  - cnt runs 0..SCAN_DIV-1.
  - tick = (cnt==SCAN_DIV-1).
  - On tick: cnt←0, idx←idx+1 (2-bit, wraps 3→0).
- Frame boundary = tick with idx==3.
- Load/commit:
  - load=1 → staging←sym, pend←1 at the next edge.
  - On a frame boundary with pend=1: shadow←staging, pend←0.
  - load and boundary in the same cycle: shadow takes the old staging value; staging takes the new sym; pend stays 1. The new value commits at the next boundary.
  - Repeated loads before a commit: the last one wins.
  - busy = pend.
- Output registers, updated every cycle from the current idx:
  - DIGIT←~(4'b0001<<idx)
  - DISPLAY←decode(shadow[4*idx+:4]), with blank/blink overrides
- Decode:
  - 0-9: standard digits (0=7'b100_0000 … 9=7'b001_0000)
  - 10 'P' = 7'b000_1100
  - 11 up = 7'b101_1100
  - 12 down = 7'b110_0011
  - 13 dash = 7'b011_1111
  - 14, 15 blank = 7'b111_1111
- Override priority: blank > blink-off > decoded symbol. DIGIT is never gated by these overrides.
- frame_done is registered: high for the one cycle following each frame-boundary edge.

## Timing
- Each digit is lit for exactly SCAN_DIV clocks; frame = 4·SCAN_DIV clocks.
- Output latency: DIGIT/DISPLAY reflect idx and shadow with 1 clk delay.
- Load-to-display latency:
  - at most one frame + 2 clk after load
  - at least 2 clk (load exactly 1 cycle before a boundary)
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). Pending staged data is discarded.
- After reset release, the first boundary occurs at rising edge 4·SCAN_DIV.

## Configuration
- SEVSEG_BLINK_EN defined:
  - The frame counter counts frame boundaries 0..BLINK_FRAMES-1; at terminal it wraps and toggles the blink phase.
  - While the phase is OFF, digits with blink_mask[idx]=1 drive DISPLAY=7'b111_1111.
  - The phase starts ON after reset.
- SEVSEG_BLINK_EN undefined:
  - The frame counter and phase logic are absent.
  - blink_mask is ignored and no digit ever blinks.
  - All other behaviour is identical.

## Structure
- Package sevseg_pkg holds:
  - symbol constants SYM_P=4'd10, SYM_UP=4'd11, SYM_DOWN=4'd12, SYM_DASH=4'd13, SYM_BLANK=4'd15
  - segment constant SEG_OFF=7'b111_1111
  - the decode function or table
- Sub-module sevseg_decoder: combinational 4-bit symbol → 7-bit active-low segments. It is reused by other display blocks.
- Top level holds the slot counter, idx, staging/shadow/pend, the blink counter and the output registers.

## Test plan
Run with SCAN_DIV=4 and BLINK_FRAMES=2 unless stated otherwise.
- **Reset:** assert rst → DIGIT=4'b1111, DISPLAY=7'h7F, busy=0 immediately. After release, DIGIT sequence 1110,1101,1011,0111, 4 clk each, all DISPLAY=7'h7F.
- **Load/commit:** load sym=16'hB123 at edge 2 → busy=1 until the edge-16 boundary. Next frame shows 7'b011_0000, 7'b010_0100, 7'b111_1001, 7'b101_1100 on digits 0..3.
- **Collision:** load 16'h1111 at edge 3, then load 16'h2222 in the boundary cycle (edge 16) → frame 2 shows all '1', frame 3 shows all '2'. busy falls at edge 32.
- **Blank:** blank=1 mid-frame → DISPLAY=7'h7F from the next clk while DIGIT keeps scanning. Release restores the symbols.
- **Blink:** with SEVSEG_BLINK_EN, blink_mask=4'b0001 → digit 0 on for 2 frames, off for 2 frames, repeating; other digits are steady. Without the macro, the same stimulus gives no blinking.
- **Reset mid-operation:** rst pulse while busy=1 → staging is discarded, shadow=16'hFFFF, frame_done never pulses for the aborted frame.
